// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the demux drive sequencer.
package demux_seq_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StDrive, StGap} state_t;

  localparam int unsigned STAT_W = 8;

  function automatic int unsigned num_ch(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/demux_req_fifo.sv
// Synchronous request FIFO; full/empty tracked with an extra pointer wrap bit.
module demux_req_fifo #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             push_en, pop_en;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/demux_drive_seq.sv
// Sequencer feeding a 1-to-N decoder: buffers requests, holds each for DWELL cycles, then one idle
// cycle. Optional per-channel load counters when DEMUX_SEQ_STATS_EN is defined.
module demux_drive_seq
  import demux_seq_pkg::*;
#(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned DWELL      = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_data_i,
  input  logic [SEL_W-1:0]                req_sel_i,
  output logic                            dec_in_o,
  output logic [SEL_W-1:0]                dec_sel_o,
  output logic                            dec_active_o,
`ifdef DEMUX_SEQ_STATS_EN
  input  logic                            stat_clr_i,
  output logic [num_ch(SEL_W)*STAT_W-1:0] stat_cnt_o,
`endif
  output logic                            busy_o
);

  localparam int unsigned EntW    = SEL_W + 1;
  localparam logic [7:0]  CntInit = 8'(DWELL - 1);

  logic             fifo_full, fifo_empty, push, load;
  logic [EntW-1:0]  head;
  logic [SEL_W-1:0] head_sel;
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             dec_in_q, dec_in_d;
  logic [SEL_W-1:0] dec_sel_q, dec_sel_d;
  logic             dec_active_q, dec_active_d;

  assign req_ready_o = !fifo_full && !reset_i;
  assign push        = req_valid_i && req_ready_o;
  assign head_sel    = head[SEL_W-1:0];

  demux_req_fifo #(
    .Width (EntW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .push_i  (push),
    .pop_i   (load),
    .wdata_i ({req_data_i, req_sel_i}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dec_in_d     = dec_in_q;
    dec_sel_d    = dec_sel_q;
    dec_active_d = dec_active_q;
    load         = 1'b0;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StLoad;
      StLoad:  load = 1'b1;
      StDrive: begin
        if (cnt_q == '0) begin
          state_d      = StGap;
          dec_active_d = 1'b0;
          dec_in_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // Reload straight from the gap so back-to-back entries see exactly one idle cycle.
      StGap:   if (!fifo_empty) load = 1'b1; else state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d      = StDrive;
      cnt_d        = CntInit;
      dec_in_d     = head[EntW-1];
      dec_sel_d    = head_sel;
      dec_active_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dec_in_q     <= 1'b0;
      dec_sel_q    <= '0;
      dec_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dec_in_q     <= dec_in_d;
      dec_sel_q    <= dec_sel_d;
      dec_active_q <= dec_active_d;
    end
  end

  assign dec_in_o     = dec_in_q;
  assign dec_sel_o    = dec_sel_q;
  assign dec_active_o = dec_active_q;
  assign busy_o       = !fifo_empty || (state_q != StIdle);

`ifdef DEMUX_SEQ_STATS_EN
  localparam int unsigned NumCh = num_ch(SEL_W);

  logic [STAT_W-1:0] stat_q [NumCh];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NumCh; i++) stat_q[i] <= '0;
    end else if (stat_clr_i) begin
      for (int unsigned i = 0; i < NumCh; i++) stat_q[i] <= '0;
    end else if (load && (stat_q[head_sel] != '1)) begin
      stat_q[head_sel] <= stat_q[head_sel] + 1'b1;
    end
  end

  always_comb begin
    stat_cnt_o = '0;
    for (int unsigned i = 0; i < NumCh; i++) stat_cnt_o[i*STAT_W +: STAT_W] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_demux_drive_seq.sv
// Directed bench for demux_drive_seq (DWELL=2 and DWELL=1 instances); stats checks when
// DEMUX_SEQ_STATS_EN is defined.
module tb_demux_drive_seq;

  typedef struct packed {
    logic       v;
    logic       d;
    logic [1:0] s;
    logic       rdy;
    logic       act;
    logic [3:0] out;
    logic [1:0] dsel;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_data = 1'b0;
  logic [1:0] req_sel = '0;
  logic       req_ready, dec_in, dec_active, busy;
  logic [1:0] dec_sel;
  logic       v1 = 1'b0, d1 = 1'b0;
  logic [1:0] s1 = '0;
  logic       ready1, in1, act1, busy1;
  logic [1:0] sel1;
`ifdef DEMUX_SEQ_STATS_EN
  logic        stat_clr = 1'b0, stat_clr1 = 1'b0;
  logic [31:0] stat_cnt, stat_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_drive_seq #(.SEL_W(2), .DWELL(2), .FIFO_DEPTH(2)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .req_sel_i    (req_sel),
    .dec_in_o     (dec_in),
    .dec_sel_o    (dec_sel),
    .dec_active_o (dec_active),
`ifdef DEMUX_SEQ_STATS_EN
    .stat_clr_i   (stat_clr),
    .stat_cnt_o   (stat_cnt),
`endif
    .busy_o       (busy)
  );

  demux_drive_seq #(.SEL_W(2), .DWELL(1), .FIFO_DEPTH(2)) dut1 (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (v1),
    .req_ready_o  (ready1),
    .req_data_i   (d1),
    .req_sel_i    (s1),
    .dec_in_o     (in1),
    .dec_sel_o    (sel1),
    .dec_active_o (act1),
`ifdef DEMUX_SEQ_STATS_EN
    .stat_clr_i   (stat_clr1),
    .stat_cnt_o   (stat_cnt1),
`endif
    .busy_o       (busy1)
  );

  // Model of the downstream 1-to-4 decoder.
  function automatic logic [3:0] dec4(input logic in, input logic [1:0] sel);
    logic [3:0] one;
    one = {3'b000, in};
    return one << sel;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic run_row(input vec_t r, input int idx, input bit second);
    logic [8:0] got, exp;
    if (second) begin v1 = r.v; d1 = r.d; s1 = r.s; end
    else begin req_valid = r.v; req_data = r.d; req_sel = r.s; end
    @(negedge clk);
    if (second) got = {ready1, act1, dec4(in1, sel1), sel1, busy1};
    else        got = {req_ready, dec_active, dec4(dec_in, dec_sel), dec_sel, busy};
    exp = {r.rdy, r.act, r.out, r.dsel, r.busy};
    check(second ? "dwell1_row" : "row", idx, 32'(got), 32'(exp));
    @(posedge clk);
    #1;
  endtask

`ifdef DEMUX_SEQ_STATS_EN
  task automatic push_one(input logic [1:0] s, output bit ok);
    logic r;
    req_valid = 1'b1; req_data = 1'b1; req_sel = s; ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); r = req_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    req_valid = 1'b0;
  endtask
`endif

  vec_t vecs[$];
  vec_t vecs1[$];

  initial begin
    bit seen_act, seen_busy, seen_nrdy, got_act;
    // single request, data=1 sel=01
    vecs.push_back('{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0010, 2'b01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0010, 2'b01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b01, 1'b0});
    // back-to-back 00,01,10,11 with valid held until accepted
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b01, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 2'b01, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 4'b0001, 2'b00, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 4'b0001, 2'b00, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 4'b0010, 2'b01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'b0010, 2'b01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0100, 2'b10, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0100, 2'b10, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b1000, 2'b11, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b1000, 2'b11, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b11, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b11, 1'b0});
    // data=0 to channel 10: active without any decoder output
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 4'b0000, 2'b11, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b11, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b11, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0000, 2'b10, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0000, 2'b10, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b0});
    // DWELL=1 instance: three pushes, active toggles every cycle
    vecs1.push_back('{1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0});
    vecs1.push_back('{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b1});
    vecs1.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b1});
    vecs1.push_back('{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 4'b0001, 2'b00, 1'b1});
    vecs1.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b1});
    vecs1.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0010, 2'b01, 1'b1});
    vecs1.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b01, 1'b1});
    vecs1.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0100, 2'b10, 1'b1});
    vecs1.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b1});
    vecs1.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b0});

    // Reset state
    @(negedge clk);
    check("reset_state", 0, 32'({req_ready, dec_active, dec_in, dec_sel, busy}), 32'd0);
    check("reset_state_dwell1", 0, 32'({ready1, act1, in1, sel1, busy1}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_row(vecs[i], i, 1'b0);

    // Reset during the first dwell cycle with further entries pending
    req_valid = 1'b1; req_data = 1'b1; req_sel = 2'b10; got_act = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dec_active) begin got_act = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("wait_active", 0, 32'(got_act), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_reset", 0, 32'({req_ready, dec_active, dec_in, dec_sel, busy}), 32'd0);
    #2 reset = 1'b0; req_valid = 1'b0;
    seen_act = 1'b0; seen_busy = 1'b0; seen_nrdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      seen_act  |= dec_active;
      seen_busy |= busy;
      seen_nrdy |= !req_ready;
    end
    check("post_reset_active", 0, 32'(seen_act), 32'd0);
    check("post_reset_busy", 0, 32'(seen_busy), 32'd0);
    check("post_reset_ready", 0, 32'(seen_nrdy), 32'd0);
    @(posedge clk); #1;

    foreach (vecs1[i]) run_row(vecs1[i], i, 1'b1);

`ifdef DEMUX_SEQ_STATS_EN
    begin
      bit ok, all_ok;
      all_ok = 1'b1;
      for (int n = 0; n < 300; n++) begin
        push_one(2'b11, ok);
        all_ok &= ok;
      end
      check("stat_push_ok", 0, 32'(all_ok), 32'd1);
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (!busy) break;
      end
      check("stat_drained", 0, 32'(busy), 32'd0);
      check("stat_saturate", 0, stat_cnt, 32'hFF00_0000);
      @(posedge clk); #1;
      push_one(2'b01, ok);
      stat_clr = 1'b1;
      repeat (2) @(posedge clk);
      #1 stat_clr = 1'b0;
      @(negedge clk);
      check("stat_clr_priority", 0, stat_cnt, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
